// File: rtl/vx_credit_tx.sv
// Sender-side credit-based transmitter.
// Holds a count of free receiver slots, gates a valid/ready upstream onto a
// ready-less output link, absorbs batched credit returns and offers a drain
// sequence that waits until every credit has come home.

module vx_credit_tx #(
    parameter int CREDITS = 4,
    parameter int DATAW   = 32,
    parameter int CNTW    = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    input  logic             ret_valid,
    input  logic [CNTW-1:0]  ret_count,
    input  logic             flush,
    output logic             flush_done,
    output logic [CNTW-1:0]  credits,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Full credit count at counter width and at the widened arithmetic width.
    localparam logic [CNTW-1:0] FULL_CNT   = CNTW'(CREDITS);
    localparam logic [CNTW:0]   FULL_CNT_W = (CNTW + 1)'(CREDITS);
    localparam logic [CNTW-1:0] ZERO_CNT   = {CNTW{1'b0}};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNTW-1:0]    credits_r;
    logic [CNTW-1:0]    credits_nxt_s;
    logic               empty_r;
    logic               full_r;
    logic               overflow_r;
    logic               out_valid_r;
    logic [DATAW-1:0]   out_data_r;
    logic               flush_done_r;
    logic               flush_done_nxt_s;
    logic               in_ready_s;
    logic               send_s;
    logic               ret_ovf_s;
    logic [CNTW:0]      ret_add_s;
    logic [CNTW:0]      sum_s;

    // Upstream handshake: depends on registered state only, never on
    // in_valid or ret_valid, so a return cannot open the gate in the same
    // cycle it arrives.
    always_comb begin
        in_ready_s = 1'b0;
        send_s     = 1'b0;
        if ((credits_r != ZERO_CNT) && (state_r == ST_IDLE)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        send_s = in_valid && in_ready_s;
    end

    // Credit arithmetic in one extra bit so a too-large return is visible
    // before it is saturated back to the full count.
    always_comb begin
        ret_add_s     = {(CNTW + 1){1'b0}};
        sum_s         = {(CNTW + 1){1'b0}};
        credits_nxt_s = credits_r;
        ret_ovf_s     = 1'b0;
        if (ret_valid) begin
            ret_add_s = {1'b0, ret_count};
        end else begin
            ret_add_s = {(CNTW + 1){1'b0}};
        end
        sum_s = {1'b0, credits_r} - {{CNTW{1'b0}}, send_s} + ret_add_s;
        if (sum_s > FULL_CNT_W) begin
            credits_nxt_s = FULL_CNT;
            ret_ovf_s     = 1'b1;
        end else begin
            credits_nxt_s = sum_s[CNTW-1:0];
            ret_ovf_s     = 1'b0;
        end
    end

    // Drain FSM next state; the DONE pulse is registered alongside the state.
    always_comb begin
        state_nxt_s      = state_r;
        flush_done_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (credits_r == FULL_CNT) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (state_nxt_s == ST_DONE) begin
            flush_done_nxt_s = 1'b1;
        end else begin
            flush_done_nxt_s = 1'b0;
        end
    end

    // FSM state register and the flush_done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            flush_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            flush_done_r <= flush_done_nxt_s;
        end
    end

    // Credit counter with its status flags, all updated from the same next value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits_r  <= FULL_CNT;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            credits_r  <= credits_nxt_s;
            empty_r    <= (credits_nxt_s == FULL_CNT);
            full_r     <= (credits_nxt_s == ZERO_CNT);
            overflow_r <= overflow_r | ret_ovf_s;
        end
    end

    // One-cycle output stage; data holds its last value between sends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATAW{1'b0}};
        end else begin
            out_valid_r <= send_s;
            if (send_s) begin
                out_data_r <= in_data;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign flush_done = flush_done_r;
    assign credits    = credits_r;
    assign empty      = empty_r;
    assign full       = full_r;
    assign overflow   = overflow_r;

    vx_credit_tx_chk #(
        .CREDITS (CREDITS),
        .CNTW    (CNTW)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .ret_valid (ret_valid),
        .ret_count (ret_count),
        .credits   (credits_r)
    );

endmodule

// Protocol checks for the credit transmitter.
module vx_credit_tx_chk #(
    parameter int CREDITS = 4,
    parameter int CNTW    = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            in_ready,
    input  logic            ret_valid,
    input  logic [CNTW-1:0] ret_count,
    input  logic [CNTW-1:0] credits
);

    a_no_send_without_credit: assert property (@(posedge clk) disable iff (!reset)
        !(in_valid && in_ready && (credits == {CNTW{1'b0}})));

    a_ret_count_in_range: assert property (@(posedge clk) disable iff (!reset)
        ret_valid |-> (ret_count <= CNTW'(CREDITS)));

endmodule

// File: tb/tb_vx_credit_tx.sv
// Self-checking bench for vx_credit_tx: directed vector table, hand-written
// flush/overflow/reset sequences and randomized traffic against a
// behavioural model of the credit rules.

module tb_vx_credit_tx;

    localparam int CREDITS = 4;
    localparam int DATAW   = 32;
    localparam int CNTW    = $clog2(CREDITS + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [DATAW-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [DATAW-1:0] out_data;
    logic             ret_valid;
    logic [CNTW-1:0]  ret_count;
    logic             flush;
    logic             flush_done;
    logic [CNTW-1:0]  credits;
    logic             empty;
    logic             full;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: free-credit count, drain phase (0 idle, 1 draining,
    // 2 done) and expected output-side values.
    int               m_credits;
    int               m_phase;
    bit               m_overflow;
    bit               m_out_valid;
    logic [DATAW-1:0] m_out_data;
    bit               m_flush_done;

    always #5 clk = ~clk;

    vx_credit_tx #(.CREDITS(CREDITS), .DATAW(DATAW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .ret_valid  (ret_valid),
        .ret_count  (ret_count),
        .flush      (flush),
        .flush_done (flush_done),
        .credits    (credits),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow)
    );

    typedef struct {
        logic             iv;
        logic [DATAW-1:0] id;
        logic             rv;
        logic [CNTW-1:0]  rc;
        logic [CNTW-1:0]  e_cred;
        logic             e_rdy;
        logic             e_ov;
        logic [DATAW-1:0] e_od;
        logic             e_full;
        logic             e_empty;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credits    = CREDITS;
        m_phase      = 0;
        m_overflow   = 1'b0;
        m_out_valid  = 1'b0;
        m_out_data   = '0;
        m_flush_done = 1'b0;
    endtask

    function automatic bit model_ready();
        return (m_credits > 0) && (m_phase == 0);
    endfunction

    task automatic model_step();
        bit sent;
        int total;
        int old_credits;
        old_credits = m_credits;
        sent  = in_valid && model_ready();
        total = m_credits - (sent ? 1 : 0) + (ret_valid ? int'(ret_count) : 0);
        if (total > CREDITS) begin
            m_credits  = CREDITS;
            m_overflow = 1'b1;
        end else begin
            m_credits = total;
        end
        if (m_phase == 0 && flush)                    m_phase = 1;
        else if (m_phase == 1 && old_credits == CREDITS) m_phase = 2;
        else if (m_phase == 2)                        m_phase = 0;
        m_flush_done = (m_phase == 2);
        m_out_valid  = sent;
        if (sent) m_out_data = in_data;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".credits"},    64'(credits),    64'(m_credits));
        chk({tag, ".empty"},      64'(empty),      64'(m_credits == CREDITS));
        chk({tag, ".full"},       64'(full),       64'(m_credits == 0));
        chk({tag, ".in_ready"},   64'(in_ready),   64'(model_ready()));
        chk({tag, ".out_valid"},  64'(out_valid),  64'(m_out_valid));
        chk({tag, ".out_data"},   64'(out_data),   64'(m_out_data));
        chk({tag, ".flush_done"}, 64'(flush_done), 64'(m_flush_done));
        chk({tag, ".overflow"},   64'(overflow),   64'(m_overflow));
    endtask

    task automatic drive(input logic iv, input logic [DATAW-1:0] id, input logic rv,
                         input logic [CNTW-1:0] rc, input logic fl);
        in_valid  = iv;
        in_data   = id;
        ret_valid = rv;
        ret_count = rc;
        flush     = fl;
    endtask

    // One clock: check the combinational ready, advance the model, sample
    // one time unit after the edge and compare everything.
    task automatic tick(input string tag);
        chk({tag, ".in_ready_pre"}, 64'(in_ready), 64'(model_ready()));
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        model_reset();

        tbl[0]  = '{1'b1, 32'hA0, 1'b0, 3'd0, 3'd3, 1'b1, 1'b1, 32'hA0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'hA1, 1'b0, 3'd0, 3'd2, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'hA2, 1'b0, 3'd0, 3'd1, 1'b1, 1'b1, 32'hA2, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'hA3, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 32'hA3, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 32'hA4, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 32'hA3, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 32'hA4, 1'b1, 3'd2, 3'd2, 1'b1, 1'b0, 32'hA3, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'hA4, 1'b0, 3'd0, 3'd1, 1'b1, 1'b1, 32'hA4, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 32'hA5, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 32'hA5, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 32'h00, 1'b1, 3'd1, 3'd1, 1'b1, 1'b0, 32'hA5, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'hB0, 1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 32'hB0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'h00, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0, 32'hB0, 1'b0, 1'b0};

        // Reset state, checked while reset is still held.
        #12;
        check_model("reset");
        chk("reset.credits_const", 64'(credits), 64'd4);
        reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].rv, tbl[i].rc, 1'b0);
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.credits", i),   64'(credits),   64'(tbl[i].e_cred));
            chk($sformatf("vec%0d.in_ready", i),  64'(in_ready),  64'(tbl[i].e_rdy));
            chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("vec%0d.out_data", i),  64'(out_data),  64'(tbl[i].e_od));
            chk($sformatf("vec%0d.full", i),      64'(full),      64'(tbl[i].e_full));
            chk($sformatf("vec%0d.empty", i),     64'(empty),     64'(tbl[i].e_empty));
        end

        // Drain with 3 credits outstanding (credits=1).
        drive(1'b0, '0, 1'b0, 3'd0, 1'b1);
        tick("fl_enter");
        chk("fl_enter.in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'hC0, 1'b1, 3'd1, 1'b0);
        tick("fl_ret1");
        chk("fl_ret1.credits", 64'(credits), 64'd2);
        chk("fl_ret1.out_valid", 64'(out_valid), 64'd0);
        drive(1'b0, '0, 1'b1, 3'd2, 1'b0);
        tick("fl_ret2");
        chk("fl_ret2.credits", 64'(credits), 64'd4);
        chk("fl_ret2.flush_done", 64'(flush_done), 64'd0);
        drive(1'b0, '0, 1'b0, 3'd0, 1'b0);
        tick("fl_done");
        chk("fl_done.flush_done", 64'(flush_done), 64'd1);
        chk("fl_done.in_ready", 64'(in_ready), 64'd0);
        tick("fl_idle");
        chk("fl_idle.flush_done", 64'(flush_done), 64'd0);
        chk("fl_idle.in_ready", 64'(in_ready), 64'd1);

        // Flush with nothing outstanding completes in two cycles.
        drive(1'b0, '0, 1'b0, 3'd0, 1'b1);
        tick("fl0_a");
        drive(1'b0, '0, 1'b0, 3'd0, 1'b0);
        tick("fl0_b");
        chk("fl0_b.flush_done", 64'(flush_done), 64'd1);
        tick("fl0_c");

        // Overflow: credits=3 plus a return of 3 saturates and sticks.
        drive(1'b1, 32'hD0, 1'b0, 3'd0, 1'b0);
        tick("ov_send");
        chk("ov_send.credits", 64'(credits), 64'd3);
        drive(1'b0, '0, 1'b1, 3'd3, 1'b0);
        tick("ov_ret");
        chk("ov_ret.credits", 64'(credits), 64'd4);
        chk("ov_ret.overflow", 64'(overflow), 64'd1);
        drive(1'b1, 32'hD1, 1'b0, 3'd0, 1'b0);
        tick("ov_t1");
        drive(1'b1, 32'hD2, 1'b1, 3'd1, 1'b0);
        tick("ov_t2");
        drive(1'b0, '0, 1'b1, 3'd1, 1'b0);
        tick("ov_t3");
        chk("ov_t3.overflow", 64'(overflow), 64'd1);

        // Reset asserted mid-drain with credits=1.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hE0 + DATAW'(i), 1'b0, 3'd0, 1'b0);
            tick("rs_send");
        end
        drive(1'b0, '0, 1'b0, 3'd0, 1'b1);
        tick("rs_flush");
        drive(1'b0, '0, 1'b0, 3'd0, 1'b0);
        tick("rs_drain");
        chk("rs_drain.credits", 64'(credits), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_model("rs_async");
        chk("rs_async.credits", 64'(credits), 64'd4);
        chk("rs_async.empty", 64'(empty), 64'd1);
        @(posedge clk);
        #1;
        check_model("rs_hold");
        reset = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int rc;
            int outstanding;
            outstanding = CREDITS - m_credits;
            if ($urandom_range(0, 15) == 0) rc = $urandom_range(0, CREDITS);
            else                            rc = $urandom_range(0, outstanding);
            drive(1'($urandom_range(0, 1)), DATAW'($urandom), 1'($urandom_range(0, 2) == 0),
                  CNTW'(rc), 1'($urandom_range(0, 15) == 0));
            tick("rand");
            if (n_fail > 50) break;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_credit_tx.md
Name: vx_credit_tx

Overview:
- Sender-side credit-based transmitter.
- Complements a receiver-side occupancy tracker: the receiver counts entries it holds, and this block counts credits (free receiver slots) it may still consume.
- Gates a valid/ready input stream onto a ready-less output link and accepts batched credit returns.
- Provides a drain/flush sequence that waits until every credit is home.

Parameters:
- CREDITS, 4, receiver slot count and initial credit count (>=1).
- DATAW, 32, payload width.
- CNTW, $clog2(CREDITS+1), width of credit counters.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream request valid.
- in_data  in  DATAW  upstream payload.
- in_ready  out  1  upstream may transfer this cycle.
- out_valid  out  1  one-cycle send pulse to receiver (no backpressure).
- out_data  out  DATAW  payload, valid when out_valid.
- ret_valid  in  1  credit return strobe.
- ret_count  in  CNTW  credits returned when ret_valid (0 legal).
- flush  in  1  drain request, sampled when FSM in IDLE.
- flush_done  out  1  one-cycle pulse: all credits home after flush.
- credits  out  CNTW  credits currently available (registered).
- empty  out  1  credits == CREDITS (nothing outstanding).
- full  out  1  credits == 0 (no sends possible).
- overflow  out  1  sticky error: return exceeded CREDITS.

Behaviour:
- Reset (reset low, asynchronous assert, synchronous-safe release):
  - credits=CREDITS, empty=1, full=0.
  - out_valid=0, out_data=0.
  - flush_done=0, overflow=0.
  - FSM=IDLE.
- in_ready = (credits != 0) && (state == IDLE). Combinational from registers only; must not depend on in_valid or ret_valid.
- send = in_valid && in_ready.
- Output stage, 1-cycle latency:
  - On send, out_valid<=1 and out_data<=in_data next cycle.
  - Otherwise out_valid<=0; out_data holds its last value.
- Credit arithmetic, computed in CNTW+1 bits:
  - nxt = credits - send + (ret_valid ? ret_count : 0).
  - If nxt > CREDITS: credits<=CREDITS and overflow<=1 (sticky until reset).
  - Otherwise credits<=nxt.
- Simultaneous events:
  - Send and return in the same cycle net out; e.g. credits=0 with a 1-credit return gives in_ready the next cycle, not the same cycle.
  - A send at credits=1 together with ret_count=1 leaves credits=1.
- empty and full are registered and updated in the same edge as credits, from nxt.
- FSM:
  - IDLE: if flush=1, go to DRAIN. The same-cycle send is still permitted, since in_ready was computed in IDLE.
  - DRAIN: in_ready=0. When credits==CREDITS (registered), go to DONE.
  - DONE: flush_done=1 for exactly this cycle, then go to IDLE.
  - flush asserted while in DRAIN/DONE is ignored. A flush with nothing outstanding takes 2 cycles (IDLE->DRAIN->DONE).
- Overflow does not stall the block; the saturated count is used going forward.
- Assertions (simulation only):
  - !(in_valid && in_ready && credits==0).
  - ret_count <= CREDITS when ret_valid.
- Asserting reset mid-flush or mid-send returns all state to reset values immediately. Any credits in flight at the receiver are lost; the system must reset both ends together.

Test Plan:
- Reset then 4 back-to-back sends (CREDITS=4), data 0xA0..0xA3.
  - out_valid pulses cycles 1-4 with matching data.
  - credits 4->0, full=1, in_ready=0 on cycle 4.
  - A 5th request waits.
- credits=0, ret_valid=1, ret_count=2.
  - Next cycle credits=2, in_ready=1.
  - Two queued sends drain; credits back to 0.
- Simultaneous send and ret_count=1 at credits=1 -> credits stays 1, out_valid=1, full never asserts.
- 3 outstanding, flush=1.
  - in_ready=0 in DRAIN.
  - Returns of 1 then 2 give credits=4.
  - flush_done pulses exactly one cycle later; IDLE re-entered and in_ready=1.
- credits=3, ret_count=3 -> credits saturates at 4, overflow=1; it remains 1 after further normal traffic until reset.
- Assert reset low mid-DRAIN with credits=1 -> immediately credits=4, empty=1, flush_done=0, FSM=IDLE, out_valid=0.
